// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: alphabet size, letter type, rotor notch letters,
// output-register states and a small sanitising helper.
package enigma_pkg;

  localparam int unsigned NLETTERS = 26;

  typedef logic [4:0] letter_t;

  // Turnover (notch) letter index of the historical rotors I..V
  localparam int unsigned NOTCH_I   = 16;
  localparam int unsigned NOTCH_II  = 4;
  localparam int unsigned NOTCH_III = 21;
  localparam int unsigned NOTCH_IV  = 9;
  localparam int unsigned NOTCH_V   = 25;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Out-of-alphabet values collapse to letter 0
  function automatic letter_t letter_or_zero(letter_t v, letter_t last);
    return (v <= last) ? v : '0;
  endfunction

endpackage

// File: rtl/rotor_step_ctrl_if.sv
// Keypress / rotor-engine stream between the stepping front end and its
// neighbours. slave is the stepping block's view, master the environment's.
interface rotor_step_ctrl_if;
  import enigma_pkg::*;

  logic    key_valid;
  letter_t key_in;
  logic    key_ready;
  letter_t data_out;
  letter_t r1_pos;
  letter_t r2_pos;
  letter_t r3_pos;
  logic    out_valid;
  logic    out_ready;

  modport slave (
    input  key_valid, key_in, out_ready,
    output key_ready, data_out, r1_pos, r2_pos, r3_pos, out_valid
  );

  modport master (
    output key_valid, key_in, out_ready,
    input  key_ready, data_out, r1_pos, r2_pos, r3_pos, out_valid
  );

endinterface

// File: rtl/rotor_step_ctrl_mod26_inc.sv
// Combinational modulo-N increment with enable (N-1 wraps to 0).
module mod26_inc
  import enigma_pkg::*;
#(
  parameter int unsigned N = enigma_pkg::NLETTERS
) (
  input  letter_t i_val,
  input  logic    i_en,
  output letter_t o_val
);

  localparam letter_t LAST = letter_t'(N - 1);

  // Pass through unless enabled; wrap at the last letter
  always_comb begin
    o_val = i_val;
    if (i_en) begin
      o_val = (i_val >= LAST) ? '0 : i_val + letter_t'(1);
    end
  end

endmodule

// File: rtl/rotor_step_ctrl.sv
// Enigma rotor stepping front end: accepts one letter per keypress, steps the
// three rotors with the odometer rule (including the double step) and presents
// the letter with the post-step positions through a single output register.
module rotor_step_ctrl #(
  parameter int unsigned NOTCH1   = enigma_pkg::NOTCH_III,
  parameter int unsigned NOTCH2   = enigma_pkg::NOTCH_II,
  parameter int unsigned NLETTERS = enigma_pkg::NLETTERS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  enigma_pkg::letter_t r1_init,
  input  enigma_pkg::letter_t r2_init,
  input  enigma_pkg::letter_t r3_init,
  rotor_step_ctrl_if.slave    bus,
  output logic                key_err,
  output logic [15:0]         key_count
);
  import enigma_pkg::*;

  localparam letter_t LAST = letter_t'(NLETTERS - 1);
  localparam letter_t N1   = letter_t'(NOTCH1);
  localparam letter_t N2   = letter_t'(NOTCH2);

  out_state_t  r_state;
  out_state_t  w_state_nxt;
  letter_t     r_r1;
  letter_t     r_r2;
  letter_t     r_r3;
  letter_t     r_data;
  logic        r_key_err;
  logic [15:0] r_key_count;

  logic        w_key_ready;
  logic        w_in_range;
  logic        w_accept;
  logic        w_reject;
  logic        w_step2;
  logic        w_step3;
  letter_t     w_r1_nxt;
  letter_t     w_r2_nxt;
  letter_t     w_r3_nxt;

  assign w_key_ready = (r_state == OUT_EMPTY) | bus.out_ready;
  assign w_in_range  = (bus.key_in <= LAST);
  assign w_accept    = ~load & bus.key_valid & w_key_ready & w_in_range;
  assign w_reject    = ~load & bus.key_valid & w_key_ready & ~w_in_range;

  // r2 stepping on its own notch is the double-step anomaly
  assign w_step2 = (r_r1 == N1) | (r_r2 == N2);
  assign w_step3 = (r_r2 == N2);

  mod26_inc #(.N(NLETTERS)) u_inc_r1 (.i_val(r_r1), .i_en(w_accept),           .o_val(w_r1_nxt));
  mod26_inc #(.N(NLETTERS)) u_inc_r2 (.i_val(r_r2), .i_en(w_accept & w_step2), .o_val(w_r2_nxt));
  mod26_inc #(.N(NLETTERS)) u_inc_r3 (.i_val(r_r3), .i_en(w_accept & w_step3), .o_val(w_r3_nxt));

  // Output-register occupancy state
  always_ff @(posedge clk) begin
    if (!rst) r_state <= OUT_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Load empties the register; accept fills it; consume without a new key empties it
  always_comb begin
    w_state_nxt = r_state;
    if (load)                                        w_state_nxt = OUT_EMPTY;
    else if (w_accept)                               w_state_nxt = OUT_FULL;
    else if ((r_state == OUT_FULL) && bus.out_ready) w_state_nxt = OUT_EMPTY;
  end

  // Rotor positions, output letter, key counter and error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_data      <= '0;
      r_key_err   <= 1'b0;
      r_key_count <= '0;
    end else begin
      r_key_err <= w_reject;
      if (load) begin
        r_r1 <= letter_or_zero(r1_init, LAST);
        r_r2 <= letter_or_zero(r2_init, LAST);
        r_r3 <= letter_or_zero(r3_init, LAST);
      end else if (w_accept) begin
        r_r1        <= w_r1_nxt;
        r_r2        <= w_r2_nxt;
        r_r3        <= w_r3_nxt;
        r_data      <= bus.key_in;
        r_key_count <= r_key_count + 16'd1;
      end
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.data_out  = r_data;
  assign bus.r1_pos    = r_r1;
  assign bus.r2_pos    = r_r2;
  assign bus.r3_pos    = r_r3;
  assign bus.out_valid = (r_state == OUT_FULL);
  assign key_err       = r_key_err;
  assign key_count     = r_key_count;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Self-checking bench for rotor_step_ctrl: two instances (default notches and
// notches forced to 25) share one stimulus stream and are compared every cycle
// against an arithmetic model of the stepping rules, plus directed checks.
module tb_rotor_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst;
  logic       t_load;
  logic [4:0] t_r1i, t_r2i, t_r3i;
  logic       t_kv;
  logic [4:0] t_key;
  logic       t_ordy;

  rotor_step_ctrl_if bus_a ();
  rotor_step_ctrl_if bus_b ();

  assign bus_a.key_valid = t_kv;
  assign bus_a.key_in    = t_key;
  assign bus_a.out_ready = t_ordy;
  assign bus_b.key_valid = t_kv;
  assign bus_b.key_in    = t_key;
  assign bus_b.out_ready = t_ordy;

  logic        o_err [2];
  logic [15:0] o_cnt [2];
  logic        o_rdy [2];
  logic        o_ov  [2];
  logic [4:0]  o_data[2];
  logic [4:0]  o_r1  [2];
  logic [4:0]  o_r2  [2];
  logic [4:0]  o_r3  [2];

  assign o_rdy[0] = bus_a.key_ready;  assign o_rdy[1] = bus_b.key_ready;
  assign o_ov[0]  = bus_a.out_valid;  assign o_ov[1]  = bus_b.out_valid;
  assign o_data[0] = bus_a.data_out;  assign o_data[1] = bus_b.data_out;
  assign o_r1[0]  = bus_a.r1_pos;     assign o_r1[1]  = bus_b.r1_pos;
  assign o_r2[0]  = bus_a.r2_pos;     assign o_r2[1]  = bus_b.r2_pos;
  assign o_r3[0]  = bus_a.r3_pos;     assign o_r3[1]  = bus_b.r3_pos;

  rotor_step_ctrl u_dut_a (
    .clk(clk), .rst(t_rst), .load(t_load),
    .r1_init(t_r1i), .r2_init(t_r2i), .r3_init(t_r3i),
    .bus(bus_a), .key_err(o_err[0]), .key_count(o_cnt[0])
  );

  rotor_step_ctrl #(.NOTCH1(25), .NOTCH2(25)) u_dut_b (
    .clk(clk), .rst(t_rst), .load(t_load),
    .r1_init(t_r1i), .r2_init(t_r2i), .r3_init(t_r3i),
    .bus(bus_b), .key_err(o_err[1]), .key_count(o_cnt[1])
  );

  // Reference model state, one set per instance
  int unsigned m_notch1[2] = '{21, 25};
  int unsigned m_notch2[2] = '{4, 25};
  int unsigned m_r1[2], m_r2[2], m_r3[2], m_data[2], m_cnt[2];
  bit          m_ov[2], m_err[2];

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned sane(input int unsigned v);
    return (v < 26) ? v : 0;
  endfunction

  // One machine keypress / clock edge of the historical stepping rules
  task automatic model_edge();
    bit rdy;
    bit step2, step3;
    for (int i = 0; i < 2; i++) begin
      if (!t_rst) begin
        m_r1[i] = 0; m_r2[i] = 0; m_r3[i] = 0;
        m_data[i] = 0; m_cnt[i] = 0; m_ov[i] = 0; m_err[i] = 0;
      end else if (t_load) begin
        m_r1[i] = sane(t_r1i); m_r2[i] = sane(t_r2i); m_r3[i] = sane(t_r3i);
        m_ov[i] = 0; m_err[i] = 0;
      end else begin
        rdy      = !m_ov[i] || t_ordy;
        m_err[i] = t_kv && rdy && (t_key >= 26);
        if (t_kv && rdy && (t_key < 26)) begin
          step2 = (m_r1[i] == m_notch1[i]) || (m_r2[i] == m_notch2[i]);
          step3 = (m_r2[i] == m_notch2[i]);
          m_r1[i] = (m_r1[i] + 1) % 26;
          if (step2) m_r2[i] = (m_r2[i] + 1) % 26;
          if (step3) m_r3[i] = (m_r3[i] + 1) % 26;
          m_data[i] = t_key;
          m_ov[i]   = 1;
          m_cnt[i]  = (m_cnt[i] + 1) % 65536;
        end else if (m_ov[i] && t_ordy) begin
          m_ov[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("r1_pos[%0d]", i),    o_r1[i],   m_r1[i]);
      chk($sformatf("r2_pos[%0d]", i),    o_r2[i],   m_r2[i]);
      chk($sformatf("r3_pos[%0d]", i),    o_r3[i],   m_r3[i]);
      chk($sformatf("out_valid[%0d]", i), o_ov[i],   m_ov[i]);
      chk($sformatf("key_err[%0d]", i),   o_err[i],  m_err[i]);
      chk($sformatf("key_count[%0d]", i), o_cnt[i],  m_cnt[i]);
      if (m_ov[i]) chk($sformatf("data_out[%0d]", i), o_data[i], m_data[i]);
    end
  endtask

  // Check ready with current inputs, clock once, then check registered outputs
  task automatic cycle();
    #1;
    if (t_rst) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("key_ready[%0d]", i), o_rdy[i], (!m_ov[i] || t_ordy) ? 1 : 0);
    end
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    t_load = 0; t_kv = 0; t_key = 0;
  endtask

  int unsigned r1_before;

  initial begin
    t_rst = 0; t_load = 0; t_r1i = 0; t_r2i = 0; t_r3i = 0;
    t_kv = 0; t_key = 0; t_ordy = 1;
    @(negedge clk);

    // Reset held two cycles
    cycle(); cycle();
    t_rst = 1;
    #1;
    chk("rst_r1", o_r1[0], 0);
    chk("rst_r2", o_r2[0], 0);
    chk("rst_r3", o_r3[0], 0);
    chk("rst_out_valid", o_ov[0], 0);
    chk("rst_key_ready", o_rdy[0], 1);
    chk("rst_key_count", o_cnt[0], 0);

    // Double step from ADU: expect ADV, AEW, BFX
    t_load = 1; t_r3i = 0; t_r2i = 3; t_r1i = 20; t_kv = 1; t_key = 0;
    cycle();
    t_load = 0;
    cycle();
    chk("dbl1_r3", o_r3[0], 0); chk("dbl1_r2", o_r2[0], 3); chk("dbl1_r1", o_r1[0], 21);
    cycle();
    chk("dbl2_r3", o_r3[0], 0); chk("dbl2_r2", o_r2[0], 4); chk("dbl2_r1", o_r1[0], 22);
    cycle();
    chk("dbl3_r3", o_r3[0], 1); chk("dbl3_r2", o_r2[0], 5); chk("dbl3_r1", o_r1[0], 23);
    chk("dbl_count", o_cnt[0], 3);

    // Full wrap with notches at 25 on instance B
    t_kv = 0; t_load = 1; t_r1i = 25; t_r2i = 25; t_r3i = 25;
    cycle();
    t_load = 0; t_kv = 1; t_key = 4;
    cycle();
    chk("wrap_r1", o_r1[1], 0); chk("wrap_r2", o_r2[1], 0); chk("wrap_r3", o_r3[1], 0);

    // Backpressure: consume first, then stall
    idle(); t_ordy = 1;
    cycle();
    r1_before = o_r1[0];
    t_ordy = 0; t_kv = 1; t_key = 7;
    cycle();
    chk("bp_valid", o_ov[0], 1);
    chk("bp_data", o_data[0], 7);
    chk("bp_ready", o_rdy[0], 0);
    t_key = 9;
    cycle();
    chk("bp_hold_data", o_data[0], 7);
    chk("bp_hold_r1", o_r1[0], (r1_before + 1) % 26);
    t_ordy = 1; t_key = 8;
    cycle();
    chk("bp_data2", o_data[0], 8);
    chk("bp_r1_total", o_r1[0], (r1_before + 2) % 26);

    // Out-of-range key
    idle();
    cycle();
    t_kv = 1; t_key = 27;
    cycle();
    chk("err_pulse", o_err[0], 1);
    chk("err_valid", o_ov[0], 0);
    idle();
    cycle();
    chk("err_clear", o_err[0], 0);

    // Load beats key, and out-of-range init values become 0
    t_load = 1; t_r1i = 2; t_r2i = 30; t_r3i = 6; t_kv = 1; t_key = 3;
    cycle();
    chk("ldpri_r1", o_r1[0], 2); chk("ldpri_r2", o_r2[0], 0); chk("ldpri_r3", o_r3[0], 6);
    chk("ldpri_valid", o_ov[0], 0);
    t_load = 0; t_key = 5;
    cycle();
    chk("pre_rst_valid", o_ov[0], 1);
    // Reset beats a pending output and an offered key
    t_rst = 0; t_ordy = 0;
    cycle();
    chk("rst_mid_valid", o_ov[0], 0);
    chk("rst_mid_r1", o_r1[0], 0);
    t_rst = 1;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      t_rst  = ($urandom_range(0, 79) != 0);
      t_load = ($urandom_range(0, 15) == 0);
      t_r1i  = 5'($urandom_range(0, 31));
      t_r2i  = 5'($urandom_range(0, 31));
      t_r3i  = 5'($urandom_range(0, 31));
      t_kv   = ($urandom_range(0, 9) < 7);
      t_key  = 5'(($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25));
      t_ordy = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rotor_step_ctrl.md
Name: rotor_step_ctrl

Overview:
- Sequential front end of the Enigma datapath; sits directly upstream of the rotor permutation stages.
- Accepts one plaintext letter per keypress and advances the three rotor positions with the historical odometer rule, including the double-step anomaly.
- Presents the letter together with the post-step positions r1_pos/r2_pos/r3_pos to the rotor engine.
- r1 is the fast (rightmost) rotor, r3 the slow (leftmost).

Parameters:
- NOTCH1, 21, r1 turnover letter index (V, rotor III); when r1 sits here pre-step, r2 steps.
- NOTCH2, 4, r2 turnover letter index (E, rotor II); when r2 sits here pre-step, r2 and r3 step.
- NLETTERS, 26, alphabet size; positions and letters wrap modulo this.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset (0 = reset).
- load  in  1  load initial positions this cycle.
- r1_init, r2_init, r3_init  in  5 each  positions applied on load.
- key_valid  in  1  letter offered.
- key_in  in  5  letter index 0..25.
- key_ready  out  1  block can accept a key this cycle.
- data_out  out  5  registered letter to rotor engine.
- r1_pos, r2_pos, r3_pos  out  5 each  post-step positions, aligned with data_out.
- out_valid  out  1  data_out/positions valid.
- out_ready  in  1  downstream consumed output.
- key_err  out  1  one-cycle pulse: rejected out-of-range key.
- key_count  out  16  accepted-key counter (debug).

Behaviour:
- Reset (rst=0 at clk edge): r1_pos=r2_pos=r3_pos=0, data_out=0, out_valid=0, key_err=0, key_count=0. Reset wins over every other input, mid-transaction included; any pending output is dropped.
- key_ready = !out_valid | out_ready (single output register, no skid). A key is accepted when key_valid & key_ready & !load.
- Load: when load=1, positions take the init values next edge, out_valid clears, and key_valid is ignored that cycle (load has priority). Init values >25 are reduced to 0.
- Accepted key, same edge:
  - r1 <= r1+1.
  - r2 <= r2+1 if (r1==NOTCH1) | (r2==NOTCH2).
  - r3 <= r3+1 if (r2==NOTCH2).
  - All comparisons use pre-step values; each increment wraps 25->0.
  - data_out <= key_in; out_valid <= 1; key_count <= key_count+1, wrapping at 16'hFFFF->0.
- Latency: exactly 1 cycle from key acceptance to out_valid with stepped positions. Positions therefore encode the letter with rotors already stepped, as on the machine.
- Out-of-range key (key_in >= 26) while key_ready:
  - not accepted: no step, no count, out_valid unchanged.
  - key_err pulses 1 next cycle.
- Output hold: while out_valid & !out_ready, data_out and positions hold, key_ready=0, and no stepping occurs.
- Simultaneous consume and new key (out_valid & out_ready & key_valid): the new key is accepted, and out_valid stays 1 with new data (full throughput, 1 key/cycle).
- Consume without new key: out_valid clears next edge; positions keep their last values.
- Positions only change on load, accepted key, or reset.

Decomposition:
- Shared package (enigma_pkg): NLETTERS, letter_t (5-bit), standard notch constants NOTCH_I=16, NOTCH_II=4, NOTCH_III=21, NOTCH_IV=9, NOTCH_V=25.
- One natural sub-module, mod26_inc: combinational wrap-increment with enable, instantiated three times.
- The stepping decision and handshake register stay in the top.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 -> all positions 0, out_valid=0, key_ready=1, key_count=0.
- Double step: load r3=0,r2=3,r1=20 (ADU), then 3 keys of 0 with out_ready=1 -> outputs (r3,r2,r1) = (0,3,21), (0,4,22), (1,5,23) (ADV, AEW, BFX); key_count=3.
- Wrap: load 25,25,25, force NOTCH1=25/NOTCH2=25 via parameters, one key -> positions 0,0,0.
- Backpressure: out_ready=0, key 7 accepted -> out_valid=1, key_ready=0; a second key is held off with no position change; out_ready=1 with key 8 -> data_out=8 next cycle, r1 advanced by exactly 2 total.
- Invalid key: key_in=27 -> key_err pulse 1 cycle, positions and key_count unchanged, out_valid unchanged.
- Priorities: load and key_valid asserted the same cycle -> init values loaded, no step. rst=0 while out_valid=1 -> out_valid=0 and positions 0 next edge.
